ads8861_sampler: RTL and testbench

- Control and post-processing stage around the ADS8861 serial-capture block.
- Issues periodic one-cycle conversion requests on that block's en input and uses its adc_idle output to detect conversion completion.
- Captures each 16-bit adcdata word, forms a boxcar average over 2^AVG_LOG2 samples, and presents the result on a valid/ready stream to downstream logic.

---
 rtl/ads8861_sampler.sv | 230 +++++++++++++++++++++++
 tb/tb_ads8861_sampler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads8861_sampler.sv
`timescale 1ns/1ps
// ads8861_sampler: paces conversions of the ADS8861 capture block, collects
// each finished 16-bit word, boxcar-averages 2^AVG_LOG2 of them and hands the
// result to downstream logic over a valid/ready stream. Two sticky flags
// report lost results / missed trigger slots and a capture block that never
// started converting.
module ads8861_sampler #(
  parameter int unsigned PERIOD       = 200,  // clk cycles between triggers, 120..65535
  parameter int unsigned AVG_LOG2     = 2,    // log2 of samples per average, 0..4
  parameter int unsigned BUSY_TIMEOUT = 16    // cycles allowed for adc_idle to fall
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        run,
  output logic        adc_en,
  input  logic        adc_idle,
  input  logic [15:0] adcdata,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overrun,
  output logic        adc_fault,
  input  logic        clr_flags
);

  // Sum is wide enough for 2^AVG_LOG2 full-scale samples, so it never wraps.
  localparam int unsigned SUM_W = 16 + AVG_LOG2;
  // Sample counter needs at least one bit even in pass-through mode.
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [15:0]      PERIOD_LAST  = 16'(PERIOD - 1);
  localparam logic [15:0]      TIMEOUT_LAST = 16'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_BUSY,
    WAIT_DONE,
    ACCUM
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [15:0]        period_reg;
  logic               run_reg;
  logic [15:0]        timeout_reg;
  logic [15:0]        sample_reg;
  logic [SUM_W-1:0]   sum_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [15:0]        m_data_reg;
  logic               m_valid_reg;

  logic               tick;
  logic               run_rise;
  logic               group_last;
  logic [SUM_W-1:0]   sum_total;
  logic [15:0]        avg;
  logic               missed_slot;
  logic               timeout_hit;
  logic               capture;
  logic               accum;
  logic               load;
  logic               drop;

  // Sticky flags: index 0 = overrun, index 1 = adc_fault.
  logic               flag_set [2];
  logic               flag_reg [2];

  // Expiry tick only exists while running; the counter sits at 0 otherwise.
  assign tick       = run && (period_reg == PERIOD_LAST);
  // The start trigger fires in the same cycle run is first seen high; the
  // period counter is still 0 then, so later ticks follow on its own cadence.
  assign run_rise   = run && !run_reg;
  assign group_last = (count_reg == CNT_LAST);
  assign sum_total  = sum_reg + SUM_W'(sample_reg);
  assign avg        = 16'(sum_total >> AVG_LOG2);

  // A slot is missed whenever a tick arrives and a trigger cannot be issued:
  // either the FSM is still busy with the previous conversion, or it is idle
  // but the capture block reports it is converting.
  assign missed_slot = tick && !((state_reg == IDLE) && adc_idle);

  // Completed average: loads if the output register is free (or being freed
  // this cycle), otherwise it is dropped and flagged.
  assign load = accum && group_last && (!m_valid_reg || m_ready);
  assign drop = accum && group_last && !load;

  // Next-state and per-state strobes.
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    capture     = 1'b0;
    accum       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (run && adc_idle && (run_rise || tick)) begin
          state_next = TRIG;
        end
      end
      TRIG: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!adc_idle) begin
          state_next = WAIT_DONE;
        end else if (timeout_reg == TIMEOUT_LAST) begin
          // Capture block never started: abandon this sample untouched.
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      WAIT_DONE: begin
        if (adc_idle) begin
          capture    = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        accum      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Sample-period counter, free-running 0..PERIOD-1 while run is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_reg <= 16'd0;
    end else if (!run) begin
      period_reg <= 16'd0;
    end else if (period_reg == PERIOD_LAST) begin
      period_reg <= 16'd0;
    end else begin
      period_reg <= period_reg + 16'd1;
    end
  end

  // Delayed copy of run for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_reg <= 1'b0;
    end else begin
      run_reg <= run;
    end
  end

  // Cycles spent waiting for the capture block to report busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_reg <= 16'd0;
    end else if (state_reg == TRIG) begin
      timeout_reg <= 16'd0;
    end else if (state_reg == WAIT_BUSY) begin
      timeout_reg <= timeout_reg + 16'd1;
    end
  end

  // Latch the conversion result on the first idle cycle after busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_reg <= 16'd0;
    end else if (capture) begin
      sample_reg <= adcdata;
    end
  end

  // Boxcar accumulator; a partial group survives run going low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg   <= '0;
      count_reg <= '0;
    end else if (accum) begin
      if (group_last) begin
        sum_reg   <= '0;
        count_reg <= '0;
      end else begin
        sum_reg   <= sum_total;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  // Output stream register: holds data steady until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_reg  <= 16'd0;
      m_valid_reg <= 1'b0;
    end else if (load) begin
      m_data_reg  <= avg;
      m_valid_reg <= 1'b1;
    end else if (m_valid_reg && m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

  assign flag_set[0] = missed_slot || drop;
  assign flag_set[1] = timeout_hit;

  for (genvar gi = 0; gi < 2; gi++) begin : g_flag
    // Sticky flag; a set event in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        flag_reg[gi] <= 1'b0;
      end else if (flag_set[gi]) begin
        flag_reg[gi] <= 1'b1;
      end else if (clr_flags) begin
        flag_reg[gi] <= 1'b0;
      end
    end
  end

  assign adc_en    = (state_reg == TRIG);
  assign m_data    = m_data_reg;
  assign m_valid   = m_valid_reg;
  assign overrun   = flag_reg[0];
  assign adc_fault = flag_reg[1];

endmodule

// File: tb/tb_ads8861_sampler.sv
`timescale 1ns/1ps
// Bench for ads8861_sampler: two instances (PERIOD=200 pass-through and
// PERIOD=120 four-sample average), each with a behavioural capture-block model
// and a scoreboard monitor that checks every accepted output word.
module tb_ads8861_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        run_a, adc_en_a, adc_idle_a, m_valid_a, m_ready_a, overrun_a, adc_fault_a, clr_a;
  logic [15:0] adcdata_a, m_data_a;
  logic        run_b, adc_en_b, adc_idle_b, m_valid_b, m_ready_b, overrun_b, adc_fault_b, clr_b;
  logic [15:0] adcdata_b, m_data_b;

  ads8861_sampler #(.PERIOD(200), .AVG_LOG2(0), .BUSY_TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .adc_en(adc_en_a), .adc_idle(adc_idle_a),
    .adcdata(adcdata_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready_a),
    .overrun(overrun_a), .adc_fault(adc_fault_a), .clr_flags(clr_a)
  );

  ads8861_sampler #(.PERIOD(120), .AVG_LOG2(2), .BUSY_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .adc_en(adc_en_b), .adc_idle(adc_idle_b),
    .adcdata(adcdata_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
    .overrun(overrun_b), .adc_fault(adc_fault_b), .clr_flags(clr_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture-block model state and scoreboards.
  int          conv_a = 20, conv_b = 20;
  bit          nobusy_a = 1'b0;
  logic [15:0] data_qa[$], data_qb[$];
  logic [15:0] exp_qa[$], exp_qb[$];
  int          en_a[$], en_b[$];
  int          rise_a = 0;
  int          done_a = 0, done_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic int count_of(input int sel);
    case (sel)
      0: return en_a.size();
      1: return en_b.size();
      2: return done_a;
      3: return done_b;
      4: return (exp_qa.size() == 0) ? 1 : 0;
      5: return (exp_qb.size() == 0) ? 1 : 0;
      6: return adc_fault_a ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Bounded wait: an expired budget counts as a failed comparison.
  task automatic wait_until(input string name, input int sel, input int target, input int budget);
    int n = 0;
    while (count_of(sel) < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (count_of(sel) < target) begin
      errors++;
      $display("FAIL %s: timeout, got %0d, expected %0d", name, count_of(sel), target);
    end else begin
      $display("ok   %s: reached %0d after %0d cycles", name, target, n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Capture block A: goes busy on en, returns the next queued word after conv_a cycles.
  initial begin
    adc_idle_a = 1'b1;
    adcdata_a  = 16'h0000;
    forever begin
      @(negedge clk);
      if (adc_en_a === 1'b1 && !nobusy_a) begin
        adc_idle_a = 1'b0;
        repeat (conv_a) @(negedge clk);
        adcdata_a  = (data_qa.size() > 0) ? data_qa.pop_front() : 16'h0000;
        adc_idle_a = 1'b1;
        rise_a     = cyc;
        done_a++;
      end
    end
  end

  // Capture block B.
  initial begin
    adc_idle_b = 1'b1;
    adcdata_b  = 16'h0000;
    forever begin
      @(negedge clk);
      if (adc_en_b === 1'b1) begin
        adc_idle_b = 1'b0;
        repeat (conv_b) @(negedge clk);
        adcdata_b  = (data_qb.size() > 0) ? data_qb.pop_front() : 16'h0000;
        adc_idle_b = 1'b1;
        done_b++;
      end
    end
  end

  // Trigger logger.
  initial begin
    forever begin
      @(negedge clk);
      if (adc_en_a === 1'b1) en_a.push_back(cyc);
      if (adc_en_b === 1'b1) en_b.push_back(cyc);
    end
  end

  // Monitor A: latency on each new word, data on each handshake.
  initial begin
    logic pv_a;
    pv_a = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid_a && !pv_a) check("A valid latency", cyc - rise_a, 2);
      if (m_valid_a && m_ready_a) begin
        if (exp_qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL A unexpected output: got 0x%0h, expected none", m_data_a);
        end else begin
          check("A m_data", m_data_a, exp_qa.pop_front());
        end
      end
      pv_a = m_valid_a;
    end
  end

  // Monitor B.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid_b && m_ready_b) begin
        if (exp_qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL B unexpected output: got 0x%0h, expected none", m_data_b);
        end else begin
          check("B m_data", m_data_b, exp_qb.pop_front());
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;
    int p1;
    rst = 1'b0;
    run_a = 1'b0; run_b = 1'b0;
    m_ready_a = 1'b1; m_ready_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    step(3);

    // Reset state.
    check("A reset adc_en", adc_en_a, 0);
    check("A reset m_valid", m_valid_a, 0);
    check("A reset m_data", m_data_a, 0);
    check("A reset overrun", overrun_a, 0);
    check("A reset adc_fault", adc_fault_a, 0);
    check("B reset m_valid", m_valid_b, 0);
    rst = 1'b1;
    step(2);

    // Pass-through: three conversions, steady-state trigger spacing.
    data_qa = {16'h1234, 16'hABCD, 16'h0F0F};
    exp_qa  = {16'h1234, 16'hABCD, 16'h0F0F};
    run_a = 1'b1;
    wait_until("A three triggers", 0, 3, 700);
    run_a = 1'b0;
    if (en_a.size() >= 3) check("A trigger spacing", en_a[2] - en_a[1], 200);
    wait_until("A pass-through drained", 4, 1, 100);
    step(5);

    // Backpressure: second word dropped, overrun set, then cleared.
    m_ready_a = 1'b0;
    base  = en_a.size();
    dbase = done_a;
    data_qa.push_back(16'h0001);
    data_qa.push_back(16'h0002);
    exp_qa.push_back(16'h0001);
    run_a = 1'b1;
    wait_until("A two triggers", 0, base + 2, 500);
    run_a = 1'b0;
    wait_until("A two conversions", 2, dbase + 2, 100);
    step(3);
    check("A bp m_valid held", m_valid_a, 1);
    check("A bp m_data held", m_data_a, 16'h0001);
    check("A bp overrun", overrun_a, 1);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("A overrun cleared", overrun_a, 0);
    m_ready_a = 1'b1;
    step(3);
    check("A m_valid after accept", m_valid_a, 0);
    check("A bp queue empty", exp_qa.size(), 0);

    // Fault: capture block never goes busy.
    nobusy_a = 1'b1;
    base = en_a.size();
    run_a = 1'b1;
    wait_until("A fault trigger", 0, base + 1, 50);
    p1 = (en_a.size() > base) ? en_a[base] : cyc;
    wait_until("A adc_fault set", 6, 1, 40);
    check("A fault delay in 16..17", ((cyc - p1) >= 16 && (cyc - p1) <= 17) ? 1 : 0, 1);
    check("A fault m_valid", m_valid_a, 0);
    wait_until("A fault retriggers", 0, base + 3, 500);
    run_a = 1'b0;
    if (en_a.size() >= base + 3) begin
      check("A retrigger waits for tick", (en_a[base + 1] - en_a[base] >= 150) ? 1 : 0, 1);
      check("A fault trigger spacing", en_a[base + 2] - en_a[base + 1], 200);
    end
    step(30);
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("A adc_fault cleared", adc_fault_a, 0);
    nobusy_a = 1'b0;

    // run falls during WAIT_DONE: sample completes, no new trigger.
    conv_a = 60;
    base = en_a.size();
    data_qa.push_back(16'h7777);
    exp_qa.push_back(16'h7777);
    run_a = 1'b1;
    wait_until("A stop trigger", 0, base + 1, 50);
    step(10);
    run_a = 1'b0;
    step(300);
    check("A triggers after stop", en_a.size() - base, 1);
    check("A stop queue empty", exp_qa.size(), 0);

    // Reset during WAIT_DONE with a held output word.
    m_ready_a = 1'b0;
    base = en_a.size();
    data_qa.push_back(16'h4444);
    data_qa.push_back(16'h9999);
    run_a = 1'b1;
    wait_until("A pre-reset triggers", 0, base + 2, 500);
    step(10);
    check("A pre-reset m_valid", m_valid_a, 1);
    check("A pre-reset m_data", m_data_a, 16'h4444);
    run_a = 1'b0;
    rst = 1'b0;
    #1;
    check("A async reset adc_en", adc_en_a, 0);
    check("A async reset m_valid", m_valid_a, 0);
    check("A async reset m_data", m_data_a, 0);
    check("A async reset overrun", overrun_a, 0);
    check("A async reset adc_fault", adc_fault_a, 0);
    step(3);
    rst = 1'b1;
    m_ready_a = 1'b1;
    step(100);
    check("A m_valid after reset", m_valid_a, 0);
    check("A no trigger after reset", en_a.size() - base, 2);

    // Averaging: 10+20+30+41 = 101, >>2 = 25.
    conv_b = 20;
    data_qb = {16'd10, 16'd20, 16'd30, 16'd41};
    exp_qb.push_back(16'd25);
    run_b = 1'b1;
    wait_until("B three conversions", 3, 3, 500);
    step(3);
    check("B no output after 3", m_valid_b, 0);
    wait_until("B four triggers", 1, 4, 200);
    run_b = 1'b0;
    wait_until("B average drained", 5, 1, 100);

    // Missed slot: 130-cycle conversions against a 120-cycle period.
    conv_b = 130;
    base = en_b.size();
    data_qb = {16'd100, 16'd100, 16'd100, 16'd100};
    exp_qb.push_back(16'd100);
    check("B overrun before", overrun_b, 0);
    run_b = 1'b1;
    wait_until("B slow triggers", 1, base + 4, 1200);
    run_b = 1'b0;
    check("B missed-slot overrun", overrun_b, 1);
    if (en_b.size() >= base + 4) begin
      check("B skip spacing 1", en_b[base + 2] - en_b[base + 1], 240);
      check("B skip spacing 2", en_b[base + 3] - en_b[base + 2], 240);
    end
    wait_until("B slow average drained", 5, 1, 200);
    clr_b = 1'b1;
    step(1);
    clr_b = 1'b0;
    check("B overrun cleared", overrun_b, 0);

    step(5);
    check("A scoreboard empty", exp_qa.size(), 0);
    check("B scoreboard empty", exp_qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
